dti_noc_req_arb: RTL and testbench
==================================

// Module: dti_noc_req_arb
// PURPOSE
//  Packet-atomic round-robin arbiter sharing one custom-NoC request channel between N DTI protocol-converter instances (one per TBU group).
//  Sits between the per-instance GNPD converter request outputs and the single NoC request port.
//  Registered output stage (1-entry pipe), back-pressure via req_ready, new-packet gating via req_threshold, per-port enable for partial reset.
// PARAMETERS
//  N_PORT      4   number of requesting converter instances (2..8)
//  PAYLOAD_W   90  flit payload width
//  ID_W        6   srcid/tgtid width
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 reset, synchronous, active-low
//  port_en        in   N_PORT            per-port enable; 0 = port quiesced (partial reset)
//  in_valid       in   N_PORT            per-port flit valid
//  in_ready       out  N_PORT            per-port flit accepted
//  in_payload     in   N_PORT*PAYLOAD_W  per-port payload, port i at [i*PAYLOAD_W +: PAYLOAD_W]
//  in_srcid       in   N_PORT*ID_W       per-port source id
//  in_tgtid       in   N_PORT*ID_W       per-port target id
//  in_last        in   N_PORT            per-port last flit of packet
//  req_valid      out  1                 NoC flit valid (registered)
//  req_ready      in   1                 NoC accepts flit
//  req_payload    out  PAYLOAD_W         registered payload
//  req_srcid      out  ID_W              registered srcid
//  req_tgtid      out  ID_W              registered tgtid
//  req_qos        out  1                 constant 1
//  req_last       out  1                 registered last
//  req_threshold  in   1                 1 = NoC may take a new packet
//  busy           out  1                 packet locked or output register full
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-low. rst_n=0 at posedge clears state->IDLE, rr_ptr->0, out_vld->0.
//    Reset outputs: req_valid=0, req_last=0, req_payload/srcid/tgtid=0, busy=0, in_ready=0; req_qos=1 always.
//  Pipe: adv = !out_vld || req_ready. A flit accepted from port i (in_valid[i] && in_ready[i]) loads the output register on the same edge.
//    req_valid rises the next cycle (latency 1). out_vld clears on req_ready when no new flit loads.
//  FSM states IDLE, LOCK; owner register log2(N_PORT) bits.
//    IDLE: eligible[i] = in_valid[i] & port_en[i]; start_ok = req_threshold & adv.
//      Grant = first eligible index at or after rr_ptr (wrap modulo N_PORT). in_ready[grant] = start_ok, all other in_ready = 0.
//      On accept with in_last=0: ->LOCK, owner=grant.
//      On accept with in_last=1 (single-flit packet): stay IDLE, rr_ptr=grant+1 mod N_PORT.
//    LOCK: in_ready[owner] = adv; all other in_ready = 0. Ignores req_threshold and port_en.
//      A started packet always completes, with no interleave.
//      On accept with in_last=1: ->IDLE, rr_ptr=owner+1 mod N_PORT.
//  Exactly one in_ready may be high in any cycle. in_ready does not depend on the in_valid of the same port in LOCK.
//  Back-to-back: full throughput (1 flit/cycle) while req_ready=1, including an IDLE->IDLE grant switch.
//  No eligible port / threshold low in IDLE: no grant, rr_ptr holds.
//  req_ready=0 with out_vld=1: output register and all in_ready frozen, payload stable (AXI-style hold).
//  port_en falling during LOCK for the owner: packet still completes, and the port is excluded from the next arbitration.
//  busy = (state==LOCK) | out_vld.
// STRUCTURE
//  dti_pack additions: NOC_PAYLOAD_WIDTH=90, NOC_ID_WIDTH=6, typedef enum {ARB_IDLE, ARB_LOCK} arb_state_e,
//    typedef struct packed {payload, srcid, tgtid, last} noc_flit_t.
//  One sub-module: dti_rr_pick, combinational. Inputs: req vector and ptr. Outputs: one-hot grant and index, via a double-width masked priority scan.
//  Top holds the FSM, owner, rr_ptr, output register, and in_ready/mux logic.
// TESTING
//  1. N_PORT=4, ports 0..3 each send one single-flit packet simultaneously, req_ready=1
//     -> output order 0,1,2,3 on 4 consecutive cycles; rr_ptr=0 after.
//  2. Port 1 sends a 3-flit packet; port 2 is valid throughout
//     -> flits 1a,1b,1c contiguous, then port 2; in_ready[2]=0 during LOCK.
//  3. req_ready toggles 1,0,0,1 mid-packet -> req_payload/req_last stable while stalled, no flit lost or duplicated (scoreboard).
//  4. req_threshold=0 with port 0 valid in IDLE -> no in_ready for 5 cycles.
//     Threshold drops during LOCK -> packet still completes.
//  5. port_en[3]=0 while port 3 valid -> never granted; clearing it mid-packet of port 3 -> packet completes, then excluded.
//  6. rst_n=0 for 1 cycle mid-packet (LOCK, out_vld=1) -> next cycle req_valid=0, busy=0, state IDLE, grant from port 0.

Source files
------------

// File: rtl/dti_noc_req_arb_pkg.sv
// Shared types and helpers for the NoC request arbiter.
package dti_noc_req_arb_pkg;
  localparam int NOC_PAYLOAD_WIDTH = 90;
  localparam int NOC_ID_WIDTH      = 6;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  typedef struct packed {
    logic [NOC_PAYLOAD_WIDTH-1:0] payload;
    logic [NOC_ID_WIDTH-1:0]      srcid;
    logic [NOC_ID_WIDTH-1:0]      tgtid;
    logic                         last;
  } noc_flit_t;

  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/dti_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module dti_rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;

  // Upper half holds the unmasked requests so the scan wraps past N-1.
  always_comb begin
    mask  = '0;
    for (int i = 0; i < N; i++) mask[i] = (PW'(i) >= ptr);
    dbl   = {req, req & mask};
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < 2*N; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        idx   = PW'(j % N);
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
    any = found;
  end
endmodule

// File: rtl/dti_noc_req_arb.sv
// Packet-atomic round-robin arbiter feeding one registered NoC request channel.
module dti_noc_req_arb
  import dti_noc_req_arb_pkg::*;
#(
  parameter int N_PORT    = 4,
  parameter int PAYLOAD_W = 90,
  parameter int ID_W      = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORT-1:0]           port_en,
  input  logic [N_PORT-1:0]           in_valid,
  output logic [N_PORT-1:0]           in_ready,
  input  logic [N_PORT*PAYLOAD_W-1:0] in_payload,
  input  logic [N_PORT*ID_W-1:0]      in_srcid,
  input  logic [N_PORT*ID_W-1:0]      in_tgtid,
  input  logic [N_PORT-1:0]           in_last,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [PAYLOAD_W-1:0]        req_payload,
  output logic [ID_W-1:0]             req_srcid,
  output logic [ID_W-1:0]             req_tgtid,
  output logic                        req_qos,
  output logic                        req_last,
  input  logic                        req_threshold,
  output logic                        busy
);
  localparam int PW = $clog2(N_PORT);

  arb_state_e                       state, state_nxt;
  logic [PW-1:0]                    owner, rr_ptr, pick_idx, sel;
  logic [N_PORT-1:0]                eligible, pick_gnt;
  logic                             pick_any, adv, start_ok, accept, acc_last, out_vld;
  logic [N_PORT-1:0][PAYLOAD_W-1:0] pl_v;
  logic [N_PORT-1:0][ID_W-1:0]      src_v, tgt_v;

  assign pl_v  = in_payload;
  assign src_v = in_srcid;
  assign tgt_v = in_tgtid;

  assign adv      = !out_vld || req_ready;
  assign eligible = in_valid & port_en;
  assign start_ok = req_threshold & adv;
  assign accept   = |(in_valid & in_ready);
  assign sel      = (state == ARB_LOCK) ? owner : pick_idx;
  assign acc_last = in_last[sel];

  dti_rr_pick #(.N(N_PORT)) u_pick (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (state == ARB_IDLE && !acc_last) owner <= pick_idx;
        if (acc_last) rr_ptr <= PW'(rr_inc(int'(sel), N_PORT));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        ARB_IDLE: if (!acc_last) state_nxt = ARB_LOCK;
        ARB_LOCK: if (acc_last)  state_nxt = ARB_IDLE;
        default:  state_nxt = ARB_IDLE;
      endcase
    end
  end

  // In LOCK the owner's ready follows only the pipe, never its own valid.
  always_comb begin
    in_ready = '0;
    if (rst_n) begin
      case (state)
        ARB_IDLE: if (pick_any && start_ok) in_ready = pick_gnt;
        ARB_LOCK: in_ready[owner] = adv;
        default:  in_ready = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld     <= 1'b0;
      req_payload <= '0;
      req_srcid   <= '0;
      req_tgtid   <= '0;
      req_last    <= 1'b0;
    end else if (accept) begin
      out_vld     <= 1'b1;
      req_payload <= pl_v[sel];
      req_srcid   <= src_v[sel];
      req_tgtid   <= tgt_v[sel];
      req_last    <= acc_last;
    end else if (req_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign req_valid = out_vld;
  assign req_qos   = 1'b1;
  assign busy      = (state == ARB_LOCK) | out_vld;
endmodule

// File: tb/tb_dti_noc_req_arb.sv
// Scoreboard bench for dti_noc_req_arb: per-port source queues, expected-order queue.
module tb_dti_noc_req_arb;
  localparam int N  = 4;
  localparam int PW = 90;
  localparam int IW = 6;

  typedef struct {
    logic [PW-1:0] pl;
    logic [IW-1:0] src;
    logic [IW-1:0] tgt;
    logic          last;
  } flit_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    port_en, in_valid, in_ready, in_last;
  logic [N*PW-1:0] in_payload;
  logic [N*IW-1:0] in_srcid, in_tgtid;
  logic            req_valid, req_ready, req_qos, req_last, req_threshold, busy;
  logic [PW-1:0]   req_payload;
  logic [IW-1:0]   req_srcid, req_tgtid;

  dti_noc_req_arb #(.N_PORT(N), .PAYLOAD_W(PW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_srcid(in_srcid), .in_tgtid(in_tgtid), .in_last(in_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .req_srcid(req_srcid), .req_tgtid(req_tgtid), .req_qos(req_qos), .req_last(req_last),
    .req_threshold(req_threshold), .busy(busy)
  );

  always #5 clk = ~clk;

  flit_t pq[N][$];
  flit_t exp_q[$];
  logic  rdy_q[$];

  int tests = 0, fails = 0, cyc = 0, locked = -1;
  int first_fire = -1, last_fire = -1;
  logic          rst_v = 1'b0, thr = 1'b1, rdy_def = 1'b1;
  logic [N-1:0]  en_v = '1, ir_s;
  logic          stall_prev = 1'b0, prev_last;
  logic [PW-1:0] prev_pl;
  logic          thr_drop_on_lock = 1'b0, en3_drop_on_lock = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic flit_t mk(input int p, input int k, input int f, input logic last);
    flit_t x;
    x.pl   = {26'h2A5A5A5, 32'(p*1000 + k*10 + f), 32'hC0FFEE00 + 32'(f)};
    x.src  = IW'(p*3 + 1);
    x.tgt  = IW'(k);
    x.last = last;
    return x;
  endfunction

  task automatic src_pkt(input int p, input int k, input int n);
    for (int f = 0; f < n; f++) pq[p].push_back(mk(p, k, f, f == n-1));
  endtask

  task automatic exp_flit(input int p, input int k, input int f, input logic last);
    exp_q.push_back(mk(p, k, f, last));
  endtask

  task automatic exp_pkt(input int p, input int k, input int n);
    for (int f = 0; f < n; f++) exp_flit(p, k, f, f == n-1);
  endtask

  task automatic step();
    logic [N-1:0] acc;
    flit_t e, h;
    @(negedge clk);
    rst_n         = rst_v;
    req_threshold = thr;
    port_en       = en_v;
    req_ready     = (rdy_q.size() > 0) ? rdy_q.pop_front() : rdy_def;
    for (int p = 0; p < N; p++) begin
      if (pq[p].size() > 0) begin
        h = pq[p][0];
        in_valid[p] = 1'b1;
        in_payload[p*PW +: PW] = h.pl;
        in_srcid[p*IW +: IW]   = h.src;
        in_tgtid[p*IW +: IW]   = h.tgt;
        in_last[p]             = h.last;
      end else begin
        in_valid[p] = 1'b0;
        in_payload[p*PW +: PW] = '0;
        in_srcid[p*IW +: IW]   = '0;
        in_tgtid[p*IW +: IW]   = '0;
        in_last[p]             = 1'b0;
      end
    end
    #1;
    ir_s = in_ready;
    if (rst_n) chk("ready_onehot", 128'($countones(in_ready) <= 1), 128'd1);
    if (locked >= 0) chk("lock_excl", 128'(in_ready & ~(N'(1) << locked)), 128'd0);
    if (stall_prev) begin
      chk("hold_payload", 128'(req_payload), 128'(prev_pl));
      chk("hold_last", 128'(req_last), 128'(prev_last));
    end
    stall_prev = rst_n && req_valid && !req_ready;
    prev_pl    = req_payload;
    prev_last  = req_last;
    if (rst_n && req_valid && req_ready) begin
      if (exp_q.size() == 0) chk("unexpected_flit", 128'(req_payload), 128'd0);
      else begin
        e = exp_q.pop_front();
        chk("out_payload", 128'(req_payload), 128'(e.pl));
        chk("out_last", 128'(req_last), 128'(e.last));
        chk("out_srcid", 128'(req_srcid), 128'(e.src));
        chk("out_tgtid", 128'(req_tgtid), 128'(e.tgt));
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
    end
    acc = rst_n ? (in_valid & in_ready) : '0;
    @(posedge clk);
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        h = pq[p].pop_front();
        locked = h.last ? -1 : p;
      end
    end
    if (!rst_v) locked = -1;
    if (locked >= 0 && thr_drop_on_lock) thr = 1'b0;
    if (locked >= 0 && en3_drop_on_lock) en_v[3] = 1'b0;
  endtask

  task automatic run(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    step();
    step();
  endtask

  initial begin
    in_valid = '0; in_last = '0; in_payload = '0; in_srcid = '0; in_tgtid = '0;
    port_en = '1; req_ready = 1'b1; req_threshold = 1'b1; rst_n = 1'b0;

    // Reset state
    rst_v = 1'b0;
    step(); step();
    #1;
    chk("rst_req_valid", 128'(req_valid), 128'd0);
    chk("rst_req_last", 128'(req_last), 128'd0);
    chk("rst_payload", 128'(req_payload), 128'd0);
    chk("rst_ids", 128'({req_srcid, req_tgtid}), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_qos", 128'(req_qos), 128'd1);
    rst_v = 1'b1;
    step();

    // 1: four simultaneous single-flit packets, output on consecutive cycles
    for (int p = 0; p < N; p++) begin src_pkt(p, 1, 1); exp_pkt(p, 1, 1); end
    first_fire = -1;
    run("t1");
    chk("t1_consecutive", 128'(last_fire - first_fire), 128'd3);
    // pointer back at 0: port 0 wins over port 3
    src_pkt(3, 2, 1); src_pkt(0, 2, 1);
    exp_pkt(0, 2, 1); exp_pkt(3, 2, 1);
    run("t1b");

    // 2: 3-flit packet on port 1 while port 2 waits
    src_pkt(1, 3, 3); src_pkt(2, 3, 1);
    exp_pkt(1, 3, 3); exp_pkt(2, 3, 1);
    run("t2");

    // 3: back-pressure mid-packet
    src_pkt(0, 4, 3); exp_pkt(0, 4, 3);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run("t3");

    // 4: threshold low blocks a new packet, drop during LOCK is ignored
    thr = 1'b0;
    src_pkt(0, 5, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_no_ready", 128'(ir_s), 128'd0);
    end
    chk("t4_busy_idle", 128'(busy), 128'd0);
    thr = 1'b1; thr_drop_on_lock = 1'b1;
    exp_pkt(0, 5, 3);
    run("t4");
    thr_drop_on_lock = 1'b0; thr = 1'b1;

    // 5: disabled port never granted; disable mid-packet completes then excludes
    en_v = 4'b0111;
    src_pkt(3, 6, 3); src_pkt(1, 6, 1);
    exp_pkt(1, 6, 1);
    run("t5a");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_disabled", 128'(ir_s[3]), 128'd0);
    end
    en_v = 4'b1111; en3_drop_on_lock = 1'b1;
    exp_pkt(3, 6, 3);
    run("t5b");
    en3_drop_on_lock = 1'b0;
    chk("t5_en3_dropped", 128'(en_v[3]), 128'd0);
    src_pkt(3, 7, 1); src_pkt(0, 7, 1);
    exp_pkt(0, 7, 1);
    run("t5c");
    step();
    chk("t5_excluded", 128'(pq[3].size()), 128'd1);
    pq[3].delete();
    en_v = 4'b1111;
    step();

    // 6: reset mid-packet with a held output flit
    rdy_def = 1'b0;
    src_pkt(2, 8, 3);
    step(); step();
    #1;
    chk("t6_busy_pre", 128'(busy), 128'd1);
    chk("t6_valid_pre", 128'(req_valid), 128'd1);
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    #1;
    chk("t6_valid_post", 128'(req_valid), 128'd0);
    chk("t6_busy_post", 128'(busy), 128'd0);
    chk("t6_payload_post", 128'(req_payload), 128'd0);
    rdy_def = 1'b1;
    src_pkt(0, 9, 1);
    exp_pkt(0, 9, 1);
    exp_flit(2, 8, 1, 1'b0);
    exp_flit(2, 8, 2, 1'b1);
    run("t6");
    chk("t6_idle", 128'(busy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
